// File: rtl/icache_fill_ctrl.sv
// Miss/fill sequencer for the L1 instruction cache: victim selection, 4-beat line fill,
// line write-back into the data/tag/valid arrays, and single-line / whole-cache invalidation.
module icache_fill_ctrl #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_v,
    input  logic [AWID-1:0]            ip,
    input  logic                       ihit,
    input  logic [WAYS-1:0]            valid_set,
    input  logic                       inv_line,
    input  logic                       inv_all,
    input  logic [AWID-1:0]            inv_adr,
    output logic                       bus_cyc,
    output logic [AWID-1:0]            bus_adr,
    input  logic                       bus_ack,
    input  logic                       bus_err,
    input  logic [127:0]               bus_dat,
    output logic                       line_we,
    output logic [1:0]                 line_way,
    output logic [$clog2(LINES)-1:0]   line_idx,
    output logic [AWID-7:0]            line_tag,
    output logic [511:0]               line_dat,
    output logic                       vclr,
    output logic                       busy,
    output logic                       fault
);
    localparam int IDX_W = $clog2(LINES);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE, MISS_CHK, FILL, WRITE, SETTLE1, SETTLE2, INV_LINE, INV_SWEEP
    } state_t;

    typedef struct packed {
        logic             all;
        logic             line;
        logic [IDX_W-1:0] idx;
    } inv_pend_t;

    state_t                 state, state_nx;
    inv_pend_t              pend;
    logic [AWID-7:0]        miss_line;
    logic [1:0]             victim;
    logic [1:0]             rr_ptr;
    logic [1:0]             beat;
    logic [3:0][127:0]      line_buf;
    logic [IDX_W-1:0]       sweep_idx;
    logic [IDX_W-1:0]       inv_idx;
    logic                   fault_q;
    logic                   fv_d1, fv_d2;
    logic [AWID-1:0]        ip_d1, ip_d2;
    logic [1:0]             first_free;
    logic                   qual, miss, take_all, take_line;
    logic                   unused_inv_bits;

    assign unused_inv_bits = ^{inv_adr[AWID-1:IDX_W+6], inv_adr[5:0]};

    // ihit lags ip by two cycles, so only trust a miss once ip has been stable that long
    assign qual      = fv_d1 & fv_d2 & (ip_d1 == ip) & (ip_d2 == ip);
    assign miss      = fetch_v & ~ihit & qual;
    assign take_all  = inv_all | pend.all;
    assign take_line = inv_line | pend.line;

    always_comb begin
        first_free = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_set[w]) first_free = 2'(w);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (take_all)       state_nx = INV_SWEEP;
                else if (take_line) state_nx = INV_LINE;
                else if (miss)      state_nx = MISS_CHK;
            end
            MISS_CHK:  state_nx = FILL;
            FILL: begin
                if (bus_err)                        state_nx = IDLE;
                else if (bus_ack && beat == 2'd3)   state_nx = WRITE;
            end
            WRITE:     state_nx = SETTLE1;
            SETTLE1:   state_nx = SETTLE2;
            SETTLE2:   state_nx = IDLE;
            INV_LINE:  state_nx = IDLE;
            INV_SWEEP: if (sweep_idx == IDX_LAST && !inv_all) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus_cyc  = 1'b0;
        bus_adr  = '0;
        line_we  = 1'b0;
        line_way = 2'd0;
        line_idx = '0;
        line_tag = '0;
        vclr     = 1'b0;
        case (state)
            FILL: begin
                bus_cyc = 1'b1;
                bus_adr = {miss_line, beat, 4'h0};
            end
            WRITE: begin
                line_we  = 1'b1;
                line_way = victim;
                line_idx = miss_line[IDX_W-1:0];
                line_tag = miss_line;
            end
            INV_LINE: begin
                vclr     = 1'b1;
                line_idx = inv_idx;
            end
            INV_SWEEP: begin
                vclr     = 1'b1;
                line_idx = sweep_idx;
            end
            default: ;
        endcase
    end

    assign busy     = (state != IDLE) | pend.all | pend.line;
    assign fault    = fault_q;
    assign line_dat = line_buf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fv_d1     <= 1'b0;
            fv_d2     <= 1'b0;
            ip_d1     <= '0;
            ip_d2     <= '0;
            fault_q   <= 1'b0;
            miss_line <= '0;
            victim    <= 2'd0;
            rr_ptr    <= 2'd0;
            beat      <= 2'd0;
            line_buf  <= '0;
            sweep_idx <= '0;
            inv_idx   <= '0;
        end else begin
            fv_d1   <= fetch_v;
            fv_d2   <= fv_d1;
            ip_d1   <= ip;
            ip_d2   <= ip_d1;
            fault_q <= (state == FILL) && bus_err;
            case (state)
                IDLE: begin
                    if (take_all)
                        sweep_idx <= '0;
                    else if (take_line)
                        inv_idx <= inv_line ? inv_adr[IDX_W+5:6] : pend.idx;
                    else if (miss)
                        miss_line <= ip[AWID-1:6];
                end
                MISS_CHK: begin
                    beat <= 2'd0;
                    // rr pointer only moves when a valid way is actually evicted
                    if (&valid_set) begin
                        victim <= rr_ptr;
                        rr_ptr <= rr_ptr + 2'd1;
                    end else begin
                        victim <= first_free;
                    end
                end
                FILL: begin
                    if (bus_err) begin
                        beat <= 2'd0;
                    end else if (bus_ack) begin
                        line_buf[beat] <= bus_dat;
                        beat           <= beat + 2'd1;
                    end
                end
                INV_SWEEP: begin
                    if (inv_all)                    sweep_idx <= '0;
                    else if (sweep_idx == IDX_LAST) rr_ptr    <= 2'd0;
                    else                            sweep_idx <= sweep_idx + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    // Invalidates seen outside IDLE are held here; inv_all swallows any queued line invalidate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (state == IDLE) begin
            if (take_all || take_line) pend <= '0;
        end else if (inv_all && state != INV_SWEEP) begin
            pend.all  <= 1'b1;
            pend.line <= 1'b0;
        end else if (inv_line && !inv_all && !pend.all) begin
            pend.line <= 1'b1;
            pend.idx  <= inv_adr[IDX_W+5:6];
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: fill, victim choice, bus error, invalidates, reset mid-fill.
module tb_icache_fill_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_v = 1'b0, ihit = 1'b0, inv_line = 1'b0, inv_all = 1'b0;
    logic         bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0]  ip = '0, inv_adr = '0;
    logic [3:0]   valid_set = '0;
    logic [127:0] bus_dat = '0;
    logic         bus_cyc, line_we, vclr, busy, fault;
    logic [31:0]  bus_adr;
    logic [1:0]   line_way;
    logic [6:0]   line_idx;
    logic [25:0]  line_tag;
    logic [511:0] line_dat;
    int           n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_v(fetch_v), .ip(ip), .ihit(ihit),
        .valid_set(valid_set), .inv_line(inv_line), .inv_all(inv_all), .inv_adr(inv_adr),
        .bus_cyc(bus_cyc), .bus_adr(bus_adr), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_dat(bus_dat), .line_we(line_we), .line_way(line_way), .line_idx(line_idx),
        .line_tag(line_tag), .line_dat(line_dat), .vclr(vclr), .busy(busy), .fault(fault)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [127:0] beat_dat(input logic [31:0] a, input int b);
        return {32'(b), a, 32'h5A5A_0000 + 32'(b), ~a};
    endfunction

    task automatic present(input logic [31:0] a, input logic [3:0] vs);
        fetch_v = 1'b1; ihit = 1'b0; ip = a; valid_set = vs;
    endtask

    // mode: 0 normal, 1 bus_err (+ack) at at_beat, 2 inv_all pulse at at_beat, 3 reset at at_beat
    task automatic run_fill(input logic [31:0] a, input logic [1:0] way, input int mode, input int at_beat);
        logic [511:0] exp_line;
        int           to;
        int           seen;
        exp_line = '0;
        to = 0;
        while (!bus_cyc && to < 10) begin step(); to++; end
        chk("fill_start", bus_cyc, 1'b1);
        for (int b = 0; b < 4; b++) begin
            chk("bus_adr", bus_adr, {a[31:6], 2'(b), 4'h0});
            bus_ack = 1'b1;
            bus_dat = beat_dat(a, b);
            exp_line[128*b +: 128] = bus_dat;
            if (b == at_beat) begin
                case (mode)
                    1: bus_err = 1'b1;
                    2: inv_all = 1'b1;
                    3: begin rst_n = 1'b0; bus_ack = 1'b0; end
                    default: ;
                endcase
            end
            step();
            bus_ack = 1'b0; bus_err = 1'b0; inv_all = 1'b0;
            if (b == at_beat && mode == 1) begin
                chk("err_fault", fault, 1'b1);
                chk("err_cyc", bus_cyc, 1'b0);
                chk("err_we", line_we, 1'b0);
                chk("err_busy", busy, 1'b0);
                return;
            end
            if (b == at_beat && mode == 3) begin
                chk("rst_cyc", bus_cyc, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_dat", line_dat, 512'd0);
                rst_n = 1'b1; fetch_v = 1'b0;
                bus_ack = 1'b1; bus_dat = beat_dat(a, b);
                step();
                bus_ack = 1'b0;
                seen = 0;
                for (int k = 0; k < 8; k++) begin
                    if (line_we || bus_cyc) seen++;
                    step();
                end
                chk("late_ack_quiet", seen, 0);
                return;
            end
        end
        fetch_v = 1'b0;
        chk("line_we", line_we, 1'b1);
        chk("line_way", line_way, way);
        chk("line_idx", line_idx, a[12:6]);
        chk("line_tag", line_tag, a[31:6]);
        chk("line_dat", line_dat, exp_line);
        if (mode == 0) begin
            step(); chk("settle1_busy", busy, 1'b1);
            step(); chk("settle2_busy", busy, 1'b1);
            step(); chk("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        step(); step();
        chk("rst_outs", {bus_cyc, line_we, vclr, busy, fault}, 5'b0);
        chk("rst_adr", bus_adr, 32'd0);
        chk("rst_line_dat", line_dat, 512'd0);
        rst_n = 1'b1;
        step();

        // first fill: lowest invalid way
        present(32'h0000_1040, 4'b0111);
        step(); step();
        chk("pre_miss_busy", busy, 1'b0);
        step();
        chk("misschk_busy", busy, 1'b1);
        chk("misschk_cyc", bus_cyc, 1'b0);
        run_fill(32'h0000_1040, 2'd3, 0, -1);

        // round-robin over a full set
        for (int k = 0; k < 5; k++) begin
            present(32'h0000_0140 + 32'(k) * 32'h2000, 4'b1111);
            run_fill(32'h0000_0140 + 32'(k) * 32'h2000, 2'(k), 0, -1);
        end

        // bus error on beat 2, then refetch from beat 0
        present(32'h0000_3000, 4'b0000);
        run_fill(32'h0000_3000, 2'd0, 1, 2);
        step();
        chk("fault_once", fault, 1'b0);
        run_fill(32'h0000_3000, 2'd0, 0, -1);

        // inv_all during beat 1: fill still writes, then full sweep
        present(32'h0000_4000, 4'b1111);
        run_fill(32'h0000_4000, 2'd1, 2, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_sweep", {busy, vclr}, 2'b10);
        end
        for (int i = 0; i < 128; i++) begin
            step();
            chk("sweep", {busy, vclr, line_idx}, {1'b1, 1'b1, 7'(i)});
        end
        step();
        chk("post_sweep", {busy, vclr}, 2'b00);

        // inv_line and qualified miss together: invalidate first; rr pointer reset by sweep
        present(32'h0000_5000, 4'b1111);
        step(); step();
        inv_line = 1'b1; inv_adr = 32'h0000_2180;
        step();
        inv_line = 1'b0;
        chk("invl_vclr", {vclr, busy, line_we}, 3'b110);
        chk("invl_idx", line_idx, 7'd6);
        step();
        chk("invl_done", vclr, 1'b0);
        run_fill(32'h0000_5000, 2'd0, 0, -1);

        // reset during beat 2, late ack ignored
        present(32'h0000_6000, 4'b0001);
        run_fill(32'h0000_6000, 2'd1, 3, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
